// File: rtl/pipe_ctrl_hazard_if.sv
// Decode/hazard controller bus: ID-stage instruction fields in, pipeline
// control bundles, stall/flush steering and performance counters out.
interface pipe_ctrl_hazard_if #(
    parameter int unsigned ALUOP_W = 4,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned CNT_W   = 16
);
    logic               id_valid;
    logic [5:0]         id_opcode;
    logic [5:0]         id_funct;
    logic [REG_AW-1:0]  id_rs;
    logic [REG_AW-1:0]  id_rt;
    logic [REG_AW-1:0]  id_rd;
    logic               ex_cond;

    logic               pc_en;
    logic               ifid_en;
    logic               ifid_flush;
    logic               id_jump;
    logic               id_jr;
    logic [ALUOP_W-1:0] ex_aluop;
    logic               ex_alusrc_imm;
    logic               ex_branch;
    logic               ex_sext;
    logic               mem_write;
    logic               mem_sext_ld;
    logic               wb_regwrite;
    logic               wb_memtoreg;
    logic               wb_link;
    logic [REG_AW-1:0]  wb_dst;
    logic               illegal;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;

    modport master (
        output id_valid, id_opcode, id_funct, id_rs, id_rt, id_rd, ex_cond,
        input  pc_en, ifid_en, ifid_flush, id_jump, id_jr,
               ex_aluop, ex_alusrc_imm, ex_branch, ex_sext,
               mem_write, mem_sext_ld,
               wb_regwrite, wb_memtoreg, wb_link, wb_dst,
               illegal, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_opcode, id_funct, id_rs, id_rt, id_rd, ex_cond,
        output pc_en, ifid_en, ifid_flush, id_jump, id_jr,
               ex_aluop, ex_alusrc_imm, ex_branch, ex_sext,
               mem_write, mem_sext_ld,
               wb_regwrite, wb_memtoreg, wb_link, wb_dst,
               illegal, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_ctrl_hazard.sv
// 5-stage MIPS pipeline controller: ID decode, load-use / branch / jump hazard
// steering, ID/EX -> EX/MEM -> MEM/WB control registers and event counters.
module pipe_ctrl_hazard #(
    parameter int unsigned ALUOP_W = 4,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned CNT_W   = 16,
    parameter bit          HALF_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_ctrl_hazard_if.slave bus
);
    typedef struct packed {
        logic [ALUOP_W-1:0] aluop;
        logic               alusrc_imm;
        logic               branch;
        logic               sext;
        logic               memwrite;
        logic               sext_ld;
        logic               regwrite;
        logic               memtoreg;
        logic               link;
        logic [REG_AW-1:0]  dst;
    } ctrl_t;

    ctrl_t            dec, idex_d, idex_q, exmem_q, memwb_q;
    logic             dec_illegal, dec_jump, dec_jr, uses_rt;
    logic             loaduse, br_taken, stall, jump_go, bubble;
    logic             illegal_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             unused_wb_bits;

    always_comb begin
        dec         = '0;
        dec_illegal = 1'b0;
        dec_jump    = 1'b0;
        dec_jr      = 1'b0;
        uses_rt     = 1'b0;
        case (bus.id_opcode)
            6'h00: begin
                uses_rt      = 1'b1;
                dec.dst      = bus.id_rd;
                dec.regwrite = 1'b1;
                case (bus.id_funct)
                    6'h20: dec.aluop = ALUOP_W'(4'd1);
                    6'h22: dec.aluop = ALUOP_W'(4'd2);
                    6'h24: dec.aluop = ALUOP_W'(4'd3);
                    6'h25: dec.aluop = ALUOP_W'(4'd4);
                    6'h26: dec.aluop = ALUOP_W'(4'd5);
                    6'h27: dec.aluop = ALUOP_W'(4'd6);
                    6'h2A: dec.aluop = ALUOP_W'(4'd7);
                    6'h00: dec.aluop = ALUOP_W'(4'd8);
                    6'h02: dec.aluop = ALUOP_W'(4'd9);
                    6'h08: begin dec.regwrite = 1'b0; dec_jr = 1'b1; end
                    6'h09: begin dec.link = 1'b1; dec_jr = 1'b1; end
                    default: begin dec = '0; dec_illegal = 1'b1; end
                endcase
            end
            6'h08, 6'h0C, 6'h0A, 6'h0D: begin
                dec.alusrc_imm = 1'b1;
                dec.regwrite   = 1'b1;
                dec.dst        = bus.id_rt;
                case (bus.id_opcode)
                    6'h08:   dec.aluop = ALUOP_W'(4'd1);
                    6'h0C:   dec.aluop = ALUOP_W'(4'd3);
                    6'h0A:   dec.aluop = ALUOP_W'(4'd7);
                    default: dec.aluop = ALUOP_W'(4'd4);
                endcase
            end
            6'h04, 6'h05: begin
                uses_rt    = 1'b1;
                dec.branch = 1'b1;
                dec.dst    = bus.id_rt;
                dec.aluop  = (bus.id_opcode == 6'h04) ? ALUOP_W'(4'd10) : ALUOP_W'(4'd11);
            end
            6'h23, 6'h21: begin
                if (bus.id_opcode == 6'h21 && !HALF_EN) begin
                    dec_illegal = 1'b1;
                end else begin
                    dec.aluop      = ALUOP_W'(4'd1);
                    dec.alusrc_imm = 1'b1;
                    dec.regwrite   = 1'b1;
                    dec.memtoreg   = 1'b1;
                    dec.sext_ld    = (bus.id_opcode == 6'h21);
                    dec.dst        = bus.id_rt;
                end
            end
            6'h2B, 6'h29: begin
                if (bus.id_opcode == 6'h29 && !HALF_EN) begin
                    dec_illegal = 1'b1;
                end else begin
                    uses_rt        = 1'b1;
                    dec.aluop      = ALUOP_W'(4'd1);
                    dec.alusrc_imm = 1'b1;
                    dec.memwrite   = 1'b1;
                    dec.sext       = (bus.id_opcode == 6'h29);
                    dec.dst        = bus.id_rt;
                end
            end
            6'h02: dec_jump = 1'b1;
            6'h03: begin
                dec_jump     = 1'b1;
                dec.link     = 1'b1;
                dec.regwrite = 1'b1;
                dec.dst      = '1;
            end
            default: dec_illegal = 1'b1;
        endcase
        // register 0 is hardwired, so a write there is dropped at decode
        if (dec.dst == '0) dec.regwrite = 1'b0;
    end

    assign loaduse  = idex_q.memtoreg && (idex_q.dst != '0) && bus.id_valid &&
                      ((idex_q.dst == bus.id_rs) || (uses_rt && (idex_q.dst == bus.id_rt)));
    assign br_taken = idex_q.branch && bus.ex_cond;
    assign stall    = loaduse && !br_taken;
    assign jump_go  = bus.id_valid && !br_taken && !loaduse && (dec_jump || dec_jr);
    assign bubble   = br_taken || loaduse || !bus.id_valid;
    assign idex_d   = bubble ? '0 : dec;

    assign bus.pc_en      = !stall;
    assign bus.ifid_en    = !stall;
    assign bus.ifid_flush = br_taken || jump_go;
    assign bus.id_jump    = jump_go && dec_jump;
    assign bus.id_jr      = jump_go && dec_jr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q      <= '0;
            exmem_q     <= '0;
            memwb_q     <= '0;
            illegal_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            idex_q    <= idex_d;
            exmem_q   <= idex_q;
            memwb_q   <= exmem_q;
            illegal_q <= dec_illegal && !bubble;
            if (stall && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if ((br_taken || jump_go) && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign bus.ex_aluop      = idex_q.aluop;
    assign bus.ex_alusrc_imm = idex_q.alusrc_imm;
    assign bus.ex_branch     = idex_q.branch;
    assign bus.ex_sext       = idex_q.sext;
    assign bus.mem_write     = exmem_q.memwrite;
    assign bus.mem_sext_ld   = exmem_q.sext_ld;
    assign bus.wb_regwrite   = memwb_q.regwrite;
    assign bus.wb_memtoreg   = memwb_q.memtoreg;
    assign bus.wb_link       = memwb_q.link;
    assign bus.wb_dst        = memwb_q.dst;
    assign bus.illegal       = illegal_q;
    assign bus.stall_cnt     = stall_cnt_q;
    assign bus.flush_cnt     = flush_cnt_q;

    // EX/MEM-only fields ride along in MEM/WB to keep one bundle type
    assign unused_wb_bits = ^{memwb_q.aluop, memwb_q.alusrc_imm, memwb_q.branch,
                              memwb_q.sext, memwb_q.memwrite, memwb_q.sext_ld};
endmodule
